// File: rtl/scan_mux_if.sv
// Channel-selector bus: host-side controls and data in, registered selection out.
// The host drives 'master'; scan_mux sits on 'slave'.
interface scan_mux_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_CH  = 4,
  parameter int DWELL_W = 8
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                    ena;
  logic [NUM_CH*WIDTH-1:0] din;
  logic                    mode;
  logic [SEL_W-1:0]        sel_in;
  logic [DWELL_W-1:0]      dwell;
  logic [WIDTH-1:0]        dout;
  logic [SEL_W-1:0]        ch_idx;
  logic                    switch_pulse;
  logic                    valid;

  modport master (
    output ena, din, mode, sel_in, dwell,
    input  dout, ch_idx, switch_pulse, valid
  );

  modport slave (
    input  ena, din, mode, sel_in, dwell,
    output dout, ch_idx, switch_pulse, valid
  );
endinterface

// File: rtl/scan_mux.sv
// Registered N-channel selector with manual select or round-robin scan.
// dout and ch_idx update on the same edge, so switching never mixes channels.
module scan_mux #(
  parameter int WIDTH   = 4,
  parameter int NUM_CH  = 4,
  parameter int DWELL_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  scan_mux_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [DWELL_W-1:0] count;
  logic [DWELL_W-1:0] nxt_count;
  logic [SEL_W-1:0]   nidx;
  logic [WIDTH-1:0]   nxt_dout;

  // NOTE: every variable assigned here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    nidx      = bus.ch_idx;
    nxt_count = '0;
    if (!bus.mode) begin
      // Out-of-range selects are ignored; the current channel is held.
      if (int'(bus.sel_in) < NUM_CH) nidx = bus.sel_in;
    end else if (count >= bus.dwell) begin
      // Explicit wrap keeps non-power-of-2 channel counts in range.
      nidx = (bus.ch_idx == LAST_CH) ? '0 : bus.ch_idx + 1'b1;
    end else begin
      nxt_count = count + 1'b1;
    end
  end

  always_comb begin
    nxt_dout = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (nidx == SEL_W'(k)) nxt_dout = bus.din[k*WIDTH +: WIDTH];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count            <= '0;
      bus.ch_idx       <= '0;
      bus.dout         <= '0;
      bus.switch_pulse <= 1'b0;
      bus.valid        <= 1'b0;
    end else if (bus.ena) begin
      count            <= nxt_count;
      bus.ch_idx       <= nidx;
      bus.dout         <= nxt_dout;
      bus.switch_pulse <= (nidx != bus.ch_idx);
      bus.valid        <= 1'b1;
    end else begin
      bus.switch_pulse <= 1'b0;
    end
  end
endmodule
